// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating count of cycles the loader has waited; hit flags that its turn is due.
module dmem_starve_cnt
  import dmem_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_clr,
  input  logic                i_inc,
  input  logic [STARVE_W-1:0] i_limit,
  output logic                o_hit
);

  logic [STARVE_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + STARVE_W'(1);
    end
  end

  assign o_hit = (r_cnt == i_limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: pipeline has priority,
// loader gets a forced turn after STARVE_LIMIT lost cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DMEM_POWER   = 18,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [WORD_W-1:0]     m_addr,
  input  logic [WORD_W-1:0]     m_wdata,
  output logic                  m_gnt,
  output logic                  m_rvalid,
  output logic [WORD_W-1:0]     m_rdata,
  output logic                  stallM,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [WORD_W-1:0]     l_addr,
  input  logic [WORD_W-1:0]     l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [WORD_W-1:0]     l_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DMEM_POWER-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic [WORD_W-1:0]     mem_rdata
);

  logic   w_starve_hit;
  logic   w_m_gnt;
  logic   w_l_gnt;
  owner_t w_rsp_next;
  owner_t r_rsp_owner;
  logic   w_unused;

  // Byte-lane and above-depth address bits do not reach the RAM.
  assign w_unused = ^{m_addr[1:0], m_addr[WORD_W-1:DMEM_POWER+2],
                      l_addr[1:0], l_addr[WORD_W-1:DMEM_POWER+2]};

  dmem_starve_cnt u_starve (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_l_gnt),
    .i_inc   (l_req & ~w_l_gnt),
    .i_limit (STARVE_W'(STARVE_LIMIT)),
    .o_hit   (w_starve_hit)
  );

  // Everything is gated by reset so nothing leaks out while it is held low.
  assign w_m_gnt = reset & m_req & ~(l_req & w_starve_hit);
  assign w_l_gnt = reset & l_req & ~w_m_gnt;

  assign m_gnt  = w_m_gnt;
  assign l_gnt  = w_l_gnt;
  assign stallM = reset & m_req & ~w_m_gnt;
  assign mem_en = w_m_gnt | w_l_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_m_gnt) begin
      mem_we    = m_we;
      mem_addr  = m_addr[DMEM_POWER+1:2];
      mem_wdata = m_wdata;
    end else if (w_l_gnt) begin
      mem_we    = l_we;
      mem_addr  = l_addr[DMEM_POWER+1:2];
      mem_wdata = l_wdata;
    end
  end

  always_comb begin
    w_rsp_next = OWN_NONE;
    if (w_m_gnt && !m_we) begin
      w_rsp_next = OWN_PIPE;
    end else if (w_l_gnt && !l_we) begin
      w_rsp_next = OWN_LDR;
    end
  end

  // Remembers who owns the RAM read data returning next cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rsp_owner <= OWN_NONE;
    end else begin
      r_rsp_owner <= w_rsp_next;
    end
  end

  assign m_rvalid = reset & (r_rsp_owner == OWN_PIPE);
  assign l_rvalid = reset & (r_rsp_owner == OWN_LDR);
  assign m_rdata  = m_rvalid ? mem_rdata : '0;
  assign l_rdata  = l_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table plus random traffic against a reference model.
module tb_dmem_arbiter;

  localparam int unsigned DP  = 18;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_req, m_we, m_gnt, m_rvalid, stallM;
  logic [31:0]   m_addr, m_wdata, m_rdata;
  logic          l_req, l_we, l_gnt, l_rvalid;
  logic [31:0]   l_addr, l_wdata, l_rdata;
  logic          mem_en, mem_we;
  logic [DP-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DMEM_POWER(DP), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .stallM(stallM),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Synchronous-read RAM (256 words is enough for the addresses exercised) with a preload port.
  logic [31:0] ram [0:255];
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  // fin = {reset, m_req, m_we, l_req, l_we}; fexp = {m_gnt, l_gnt, stallM, mem_en, mem_we, m_rvalid, l_rvalid}
  typedef struct {
    logic [4:0]    fin;
    logic [31:0]   ma, md, la, ld;
    logic [6:0]    fexp;
    logic [DP-1:0] ad;
    logic [31:0]   wd, mrd, lrd;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: loader wait count, pending response and memory image.
  int          lost = 0;
  logic        pend_m = 1'b0, pend_l = 1'b0;
  logic [31:0] pend_d = 32'h0;
  logic [31:0] mmem [0:255];

  logic          em_g, el_g, e_st, e_en, e_we, e_mv, e_lv;
  logic [DP-1:0] e_ad;
  logic [31:0]   e_wd, e_mrd, e_lrd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DP-1:0] word_of(input logic [31:0] a);
    return DP'(a >> 2);
  endfunction

  task automatic model_predict(input vec_t v);
    logic rst, mr, mw, lr, lw;
    {rst, mr, mw, lr, lw} = v.fin;
    {em_g, el_g, e_st, e_en, e_we, e_mv, e_lv} = '0;
    e_ad = '0; e_wd = '0; e_mrd = '0; e_lrd = '0;
    if (rst) begin
      em_g = mr && !(lr && lost >= int'(LIM));
      el_g = lr && !em_g;
      e_st = mr && !em_g;
      e_en = em_g || el_g;
      if (em_g) begin
        e_we = mw; e_ad = word_of(v.ma); e_wd = v.md;
      end else if (el_g) begin
        e_we = lw; e_ad = word_of(v.la); e_wd = v.ld;
      end
      e_mv  = pend_m;
      e_lv  = pend_l;
      e_mrd = pend_m ? pend_d : 32'h0;
      e_lrd = pend_l ? pend_d : 32'h0;
    end
  endtask

  task automatic model_commit(input vec_t v);
    logic rst, mr, mw, lr, lw;
    {rst, mr, mw, lr, lw} = v.fin;
    if (!rst) begin
      lost = 0; pend_m = 1'b0; pend_l = 1'b0;
    end else begin
      pend_m = em_g && !mw;
      pend_l = el_g && !lw;
      if (e_en && !e_we) pend_d = mmem[e_ad[7:0]];
      if (e_en && e_we)  mmem[e_ad[7:0]] = e_wd;
      if (el_g)    lost = 0;
      else if (lr) lost = (lost + 1 > int'(LIM)) ? int'(LIM) : lost + 1;
    end
  endtask

  task automatic run_cycle(input vec_t v, input bit use_tab);
    {reset, m_req, m_we, l_req, l_we} = v.fin;
    m_addr = v.ma; m_wdata = v.md; l_addr = v.la; l_wdata = v.ld;
    #2;
    model_predict(v);
    chk("m_gnt",     32'(m_gnt),    32'(em_g));
    chk("l_gnt",     32'(l_gnt),    32'(el_g));
    chk("stallM",    32'(stallM),   32'(e_st));
    chk("mem_en",    32'(mem_en),   32'(e_en));
    chk("mem_we",    32'(mem_we),   32'(e_we));
    chk("mem_addr",  32'(mem_addr), 32'(e_ad));
    chk("mem_wdata", mem_wdata,     e_wd);
    chk("m_rvalid",  32'(m_rvalid), 32'(e_mv));
    chk("m_rdata",   m_rdata,       e_mrd);
    chk("l_rvalid",  32'(l_rvalid), 32'(e_lv));
    chk("l_rdata",   l_rdata,       e_lrd);
    if (use_tab) begin
      chk("tab_flags", 32'({m_gnt, l_gnt, stallM, mem_en, mem_we, m_rvalid, l_rvalid}), 32'(v.fexp));
      chk("tab_mem_addr",  32'(mem_addr), 32'(v.ad));
      chk("tab_mem_wdata", mem_wdata, v.wd);
      chk("tab_m_rdata",   m_rdata,   v.mrd);
      chk("tab_l_rdata",   l_rdata,   v.lrd);
    end
    @(posedge clk);
    model_commit(v);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {12'($urandom), 12'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
    return a;
  endfunction

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] W = 32'h12345678;

  vec_t vt[$];
  vec_t rv;
  logic m_prev_req, l_prev_req;

  initial begin
    reset = 1'b0; m_req = 1'b0; m_we = 1'b0; l_req = 1'b0; l_we = 1'b0;
    m_addr = '0; m_wdata = '0; l_addr = '0; l_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      pl_we = 1'b1; pl_addr = 8'(i);
      pl_data = 32'h5A000000 | 32'(i);
      if (i == 'h10) pl_data = D;
      if (i == 0)    pl_data = 32'h11;
      if (i == 1)    pl_data = 32'h22;
      mmem[i] = pl_data;
      @(negedge clk);
    end
    pl_we = 1'b0;

    // Reset held with both requesting, then pipeline read and a queued loader read.
    for (int i = 0; i < 3; i++) vt.push_back('{5'b01010, 'h40, 0, 'h4, 0, 7'b0000000, 0, 0, 0, 0});
    vt.push_back('{5'b11010, 'h40, 0, 'h0, 0, 7'b1001000, 'h10, 0, 0, 0});
    vt.push_back('{5'b10010, 'h0, 0, 'h0, 0, 7'b0101010, 'h0, 0, D, 0});
    vt.push_back('{5'b10000, 'h0, 0, 'h0, 0, 7'b0000001, 'h0, 0, 0, 'h11});
    // Starvation: both held high, loader forced in on cycles 4 and 9.
    vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b1001000, 'h10, 0, 0, 0});
    for (int i = 0; i < 3; i++) vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b1001010, 'h10, 0, D, 0});
    vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b0111010, 'h1, 0, D, 0});
    vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b1001001, 'h10, 0, 0, 'h22});
    for (int i = 0; i < 3; i++) vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b1001010, 'h10, 0, D, 0});
    vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b0111010, 'h1, 0, D, 0});
    // Loader write then pipeline read-after-write.
    vt.push_back('{5'b10011, 'h0, 0, 'h100, W, 7'b0101101, 'h40, W, 0, 'h22});
    vt.push_back('{5'b11000, 'h100, 0, 'h0, 0, 7'b1001000, 'h40, 0, 0, 0});
    vt.push_back('{5'b10000, 'h0, 0, 'h0, 0, 7'b0000010, 'h0, 0, W, 0});
    // Alternating owners on back-to-back reads.
    vt.push_back('{5'b11000, 'h0, 0, 'h0, 0, 7'b1001000, 'h0, 0, 0, 0});
    vt.push_back('{5'b10010, 'h0, 0, 'h4, 0, 7'b0101010, 'h1, 0, 'h11, 0});
    vt.push_back('{5'b10000, 'h0, 0, 'h0, 0, 7'b0000001, 'h0, 0, 0, 'h22});
    // Reset right after a pipeline read grant; loader wait count must restart from zero.
    vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b1001000, 'h10, 0, 0, 0});
    vt.push_back('{5'b01010, 'h40, 0, 'h4, 0, 7'b0000000, 'h0, 0, 0, 0});
    vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b1001000, 'h10, 0, 0, 0});
    for (int i = 0; i < 3; i++) vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b1001010, 'h10, 0, D, 0});
    vt.push_back('{5'b11010, 'h40, 0, 'h4, 0, 7'b0111010, 'h1, 0, D, 0});
    vt.push_back('{5'b10000, 'h0, 0, 'h0, 0, 7'b0000001, 'h0, 0, 0, 'h22});

    foreach (vt[i]) run_cycle(vt[i], 1'b1);

    // Random traffic; an ungranted request is held until the model says it was accepted.
    rv = '{5'b10000, 0, 0, 0, 0, 7'b0, 0, 0, 0, 0};
    for (int c = 0; c < 4000; c++) begin
      run_cycle(rv, 1'b0);
      m_prev_req = rv.fin[3];
      l_prev_req = rv.fin[1];
      if (!rv.fin[4] || !m_prev_req || em_g) begin
        rv.fin[3] = ($urandom_range(0, 3) != 0);
        rv.fin[2] = 1'($urandom);
        rv.ma = rand_addr();
        rv.md = $urandom;
      end
      if (!rv.fin[4] || !l_prev_req || el_g) begin
        rv.fin[1] = ($urandom_range(0, 2) != 0);
        rv.fin[0] = 1'($urandom);
        rv.la = rand_addr();
        rv.ld = $urandom;
      end
      rv.fin[4] = ($urandom_range(0, 63) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the pipeline memory stage (port m) and the program/data loader (port l).
- Pipeline has fixed priority. A saturating starvation counter forces a loader grant after STARVE_LIMIT lost cycles.
- Emits stallM so hazard logic can freeze the pipeline while the loader owns memory.
- Sits between the memory stage and the RAM array. The RAM is synchronous-read with 1-cycle latency.

Parameters:
DMEM_POWER, 18, log2 of RAM depth in words.
STARVE_LIMIT, 4, loader cycles lost before a forced grant; legal range 1..15.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low; state cleared on the clk edge where reset==0
m_req  in  1  pipeline access request
m_we  in  1  pipeline write (1) / read (0)
m_addr  in  `WORD  pipeline byte address
m_wdata  in  `WORD  pipeline write data
m_gnt  out  1  pipeline access accepted this cycle
m_rvalid  out  1  pipeline read data valid
m_rdata  out  `WORD  pipeline read data
stallM  out  1  pipeline request blocked this cycle
l_req  in  1  loader access request
l_we  in  1  loader write/read
l_addr  in  `WORD  loader byte address
l_wdata  in  `WORD  loader write data
l_gnt  out  1  loader access accepted this cycle
l_rvalid  out  1  loader read data valid
l_rdata  out  `WORD  loader read data
mem_en  out  1  RAM access enable
mem_we  out  1  RAM write enable
mem_addr  out  DMEM_POWER  RAM word address
mem_wdata  out  `WORD  RAM write data
mem_rdata  in  `WORD  RAM read data, 1 cycle after mem_en & !mem_we

Behaviour:
- Arbitration is combinational within the cycle:
  - starve_hit = (starve_cnt == STARVE_LIMIT).
  - m_gnt = m_req & !(l_req & starve_hit).
  - l_gnt = l_req & !m_gnt.
  - stallM = m_req & !m_gnt.
- At most one grant per cycle. A request is consumed only in a cycle where its gnt is 1. An ungranted requester holds req, we, addr and wdata stable until granted.
- RAM drive:
  - mem_en = m_gnt | l_gnt.
  - mem_we, mem_wdata and mem_addr come from the granted port; the address is addr[DMEM_POWER+1:2] (byte address >> 2, addr[1:0] ignored).
  - With no grant: mem_we = 0, mem_addr = 0, mem_wdata = 0.
- starve_cnt (4-bit register):
  - cleared on l_gnt;
  - otherwise incremented when l_req & !l_gnt;
  - saturates at STARVE_LIMIT;
  - holds when !l_req.
- Response routing (1-entry register rsp_owner ∈ {NONE, PIPE, LDR}):
  - Loaded each cycle: PIPE if m_gnt & !m_we, LDR if l_gnt & !l_we, else NONE.
  - Next cycle: m_rvalid = (rsp_owner == PIPE) and l_rvalid = (rsp_owner == LDR).
  - The owning port's rdata = mem_rdata; the non-owning port's rdata = 0.
- Read latency is exactly 1 cycle after grant. Writes produce no rvalid and commit at the grant edge.
- Back-to-back reads from alternating owners each get their own response on consecutive cycles. No response is lost or reordered.
- Reset (reset==0 at clk edge):
  - starve_cnt = 0, rsp_owner = NONE.
  - While reset==0, all gnt, rvalid, mem_en and mem_we are forced 0 and stallM = 0; all rdata = 0.
- Reset mid-operation: a read granted in the cycle before reset asserts gets no rvalid. Requesters must reissue after reset.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: pipeline wins and stallM = 0.
- Simultaneous requests with starve_cnt == STARVE_LIMIT: loader wins, stallM = 1, starve_cnt → 0.
- Address-equal write (one port) and read (other port) cannot coincide because grants are exclusive. Read-after-write on the next cycle returns the new data.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum logic[1:0] {OWN_NONE, OWN_PIPE, OWN_LDR} owner_t;
  - localparam STARVE_W = 4.
- `WORD comes from the existing global defines.
- One natural sub-module, dmem_starve_cnt: a saturating counter with clr, inc and limit inputs and a hit output.
- Arbitration and response mux stay in dmem_arbiter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with m_req=l_req=1 → all gnt/rvalid/mem_en 0. After release, the first cycle gives m_gnt=1.
- Pipeline read only: m_req=1, m_we=0, m_addr=0x40, RAM[0x10]=0xDEADBEEF → mem_addr=0x10 in cycle 0; m_rvalid=1 and m_rdata=0xDEADBEEF in cycle 1; l_rvalid=0.
- Starvation with STARVE_LIMIT=4:
  - Stimulus: m_req and l_req held high continuously.
  - Grant pattern: m_gnt for cycles 0-3, then l_gnt with stallM=1 in cycle 4, then m_gnt for cycles 5-8, then l_gnt in cycle 9.
- Write then read: l writes 0x12345678 to byte 0x100 in cycle 0; m reads 0x100 in cycle 1 → m_rdata=0x12345678 in cycle 2.
- Alternating reads: cycle 0 m reads 0x0 (data 0x11), cycle 1 l reads 0x4 (data 0x22) → m_rvalid/0x11 in cycle 1, l_rvalid/0x22 in cycle 2, no overlap.
- Reset mid-read: m read granted in cycle 0, reset=0 in cycle 1 → m_rvalid stays 0 and starve_cnt=0 after release.
